// File: rtl/cf_io_spi_bridge.sv
// CompactFlash I/O-mode register slave feeding a buffered SPI master (all logic in the CLK domain).
// Optional CF_SPI_IREQ_EN adds the active-low IREQ output and the CTRL[3]/STATUS[7] interrupt bits.
//
// state   | meaning
// S_IDLE  | SCLK parked at CPOL, waiting for enable and TX data
// S_LOAD  | pop TX head into the shift register
// S_SHIFT | 16 SCLK edges, one every DIV+1 CLKs
// S_DONE  | push received byte into RX (or flag overflow)
module cf_io_spi_bridge #(
    parameter int NUM_SS     = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              DDIR,
    input  logic [2:0]        A,
    input  logic              CE1,
    input  logic              IORD,
    input  logic              IOWR,
    output logic              WAIT,
    output logic              INPACK,
    output logic [NUM_SS-1:0] SS,
    output logic              SCLK,
    output logic              MOSI,
`ifdef CF_SPI_IREQ_EN
    output logic              IREQ,
`endif
    input  logic              MISO
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} spi_state_t;

    logic ce1_m, ce1_s, iord_m, iord_s, iord_d, iowr_m, iowr_s, iowr_d;
    logic [2:0] a_m, a_s, wr_addr;
    logic [7:0] wr_data, reg_rd, status;
    logic ack, wr_act, rd_act, rd_pop;
    logic rd_start, rd_end, wr_start, wr_end, wr_commit;

    logic [3:0] ctrl_q;
    logic [DIV_W-1:0] div_q;
    logic [NUM_SS-1:0] ssr_q;
    logic rx_ovf, tx_ovf, irq_pend;

    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_drop, rx_done;

    spi_state_t state, state_nx;
    logic [7:0] sh_tx, sh_tx_nx, sh_rx, sh_rx_nx;
    logic [3:0] edge_cnt, edge_nx;
    logic [DIV_W-1:0] div_cnt, div_cnt_nx;
    logic sclk_nx, mosi_nx, busy;

`ifdef CF_SPI_IREQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
    assign irq_pend = ctrl_q[3] && (!rx_empty || (tx_empty && !busy) || rx_ovf);
    assign IREQ     = !irq_pend;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
    assign irq_pend = 1'b0;
`endif

    assign rd_start  = iord_d && !iord_s && !ce1_s;
    assign rd_end    = !iord_d && iord_s;
    assign wr_start  = iowr_d && !iowr_s && !ce1_s;
    assign wr_end    = !iowr_d && iowr_s;
    assign wr_commit = wr_end && wr_act;
    assign WAIT      = !((!IORD || !IOWR) && !ack);
    assign SS        = ~ssr_q;

    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign tx_push  = wr_commit && (wr_addr == 3'd0) && !tx_full;
    assign tx_drop  = wr_commit && (wr_addr == 3'd0) && tx_full;
    assign rx_push  = rx_done && !rx_full;
    assign rx_drop  = rx_done && rx_full;
    assign rx_pop   = rd_end && rd_pop;
    assign busy     = (state != S_IDLE);
    assign status   = {irq_pend, tx_ovf, rx_ovf, busy, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        reg_rd = '0;
        case (a_s)
            3'd0: reg_rd = rx_empty ? 8'h00 : rx_mem[rx_rp];
            3'd1: reg_rd = status;
            3'd2: reg_rd = {4'b0000, ctrl_q};
            3'd3: reg_rd = div_q[7:0];
            3'd4: for (int i = 8; i < DIV_W && i < 16; i++) reg_rd[i-8] = div_q[i];
            3'd5: for (int i = 0; i < NUM_SS; i++) reg_rd[i] = ssr_q[i];
            default: reg_rd = '0;
        endcase
    end

    // Host side: strobes synchronised, data latched while synced IOWR is low
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            {ce1_m, ce1_s, iord_m, iord_s, iord_d, iowr_m, iowr_s, iowr_d} <= '1;
            a_m     <= '0;
            a_s     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            ack     <= 1'b0;
            wr_act  <= 1'b0;
            rd_act  <= 1'b0;
            rd_pop  <= 1'b0;
            D_out   <= '0;
            DDIR    <= 1'b0;
            INPACK  <= 1'b1;
        end else begin
            ce1_m  <= CE1;
            ce1_s  <= ce1_m;
            iord_m <= IORD;
            iord_s <= iord_m;
            iord_d <= iord_s;
            iowr_m <= IOWR;
            iowr_s <= iowr_m;
            iowr_d <= iowr_s;
            a_m    <= A;
            a_s    <= a_m;
            if (rd_start || wr_start) ack <= 1'b1;
            else if (rd_end || wr_end) ack <= 1'b0;
            if (!iowr_s) begin
                wr_data <= D_in;
                wr_addr <= a_s;
            end
            if (wr_start) wr_act <= 1'b1;
            else if (wr_end) wr_act <= 1'b0;
            if (rd_start) begin
                rd_act <= 1'b1;
                rd_pop <= (a_s == 3'd0) && !rx_empty;
                D_out  <= reg_rd;
                DDIR   <= 1'b1;
                INPACK <= 1'b0;
            end else if (rd_end) begin
                rd_act <= 1'b0;
                rd_pop <= 1'b0;
                DDIR   <= 1'b0;
                INPACK <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_q <= '0;
            div_q  <= '0;
            ssr_q  <= '0;
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            if (wr_commit) begin
                case (wr_addr)
                    3'd1: begin
                        if (wr_data[5]) rx_ovf <= 1'b0;
                        if (wr_data[6]) tx_ovf <= 1'b0;
                    end
                    3'd2: ctrl_q <= wr_data[3:0] & CTRL_MASK;
                    3'd3: div_q[7:0] <= wr_data;
                    3'd4: for (int i = 8; i < DIV_W && i < 16; i++) div_q[i] <= wr_data[i-8];
                    3'd5: for (int i = 0; i < NUM_SS; i++) ssr_q[i] <= wr_data[i];
                    default: ;
                endcase
            end
            // A new overflow in the same cycle as a clear wins
            if (rx_drop) rx_ovf <= 1'b1;
            if (tx_drop) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wp] <= wr_data;
        if (rx_push) rx_mem[rx_wp] <= sh_rx;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            sh_tx    <= '0;
            sh_rx    <= '0;
            edge_cnt <= '0;
            div_cnt  <= '0;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
        end else begin
            state    <= state_nx;
            sh_tx    <= sh_tx_nx;
            sh_rx    <= sh_rx_nx;
            edge_cnt <= edge_nx;
            div_cnt  <= div_cnt_nx;
            SCLK     <= sclk_nx;
            MOSI     <= mosi_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        sh_tx_nx   = sh_tx;
        sh_rx_nx   = sh_rx;
        edge_nx    = edge_cnt;
        div_cnt_nx = div_cnt;
        sclk_nx    = SCLK;
        mosi_nx    = MOSI;
        tx_pop     = 1'b0;
        rx_done    = 1'b0;
        case (state)
            S_IDLE: begin
                sclk_nx = ctrl_q[1];
                if (ctrl_q[0] && !tx_empty) state_nx = S_LOAD;
            end
            S_LOAD: begin
                tx_pop     = 1'b1;
                sh_tx_nx   = tx_mem[tx_rp];
                sh_rx_nx   = '0;
                edge_nx    = '0;
                div_cnt_nx = div_q;
                if (!ctrl_q[2]) mosi_nx = tx_mem[tx_rp][7];
                state_nx   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt != '0) begin
                    div_cnt_nx = div_cnt - DIV_W'(1);
                end else begin
                    div_cnt_nx = div_q;
                    sclk_nx    = !SCLK;
                    edge_nx    = edge_cnt + 4'd1;
                    // edge_cnt counts edges already taken, so even edge_cnt is an odd edge
                    if (edge_cnt[0] == ctrl_q[2]) begin
                        sh_rx_nx = {sh_rx[6:0], MISO};
                    end else begin
                        mosi_nx  = ctrl_q[2] ? sh_tx[7] : sh_tx[6];
                        sh_tx_nx = {sh_tx[6:0], 1'b0};
                    end
                    if (edge_cnt == 4'd15) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                rx_done  = 1'b1;
                state_nx = (ctrl_q[0] && !tx_empty) ? S_LOAD : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cf_io_spi_bridge.sv
// Directed bench for cf_io_spi_bridge: host I/O cycles, SPI loopback, FIFO limits and async reset.
module tb_cf_io_spi_bridge;
    localparam int NSS   = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] d_in = '0;
    logic [7:0] d_out;
    logic ddir, wait_n, inpack, sclk, mosi, miso;
    logic [2:0] a = '0;
    logic ce1 = 1'b1, iord = 1'b1, iowr = 1'b1;
    logic [NSS-1:0] ss;
    logic loop_en = 1'b0;

    assign miso = loop_en ? mosi : 1'b0;

    cf_io_spi_bridge #(.NUM_SS(NSS), .FIFO_DEPTH(DEPTH), .DIV_W(8)) dut (
        .CLK(clk), .RESET(rst_n), .D_in(d_in), .D_out(d_out), .DDIR(ddir), .A(a),
        .CE1(ce1), .IORD(iord), .IOWR(iowr), .WAIT(wait_n), .INPACK(inpack),
        .SS(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // SCLK edge log and MOSI capture on the sampling edge of the current mode
    logic sclk_prev = 1'b0, mosi_prev = 1'b0;
    logic mon_cpol = 1'b0, mon_cpha = 1'b0;
    logic [7:0] mosi_log = '0;
    int sclk_edges = 0, mosi_bad = 0;
    int edge_cyc [1024];
    always @(negedge clk) begin
        if (sclk !== sclk_prev) begin
            sclk_edges++;
            edge_cyc[sclk_edges % 1024] = cyc;
            if (sclk === !(mon_cpol ^ mon_cpha)) mosi_log = {mosi_log[6:0], mosi};
        end
        if (mosi !== mosi_prev && !(sclk_prev === 1'b1 && sclk === 1'b0)) mosi_bad++;
        sclk_prev = sclk;
        mosi_prev = mosi;
    end

    int n_tests = 0, n_fail = 0;
    int raise_cyc = 0;
    logic [7:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; d_in = data; ce1 = 1'b0;
        @(negedge clk);
        iowr = 1'b0;
        repeat (5) @(negedge clk);
        iowr = 1'b1;
        raise_cyc = cyc;
        repeat (4) @(negedge clk);
        ce1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic io_read(input logic [2:0] addr, output logic [7:0] data,
                           output logic wait_lo, output logic ddir_on, output logic inpack_lo);
        @(negedge clk);
        a = addr; ce1 = 1'b0;
        @(negedge clk);
        iord = 1'b0;
        @(negedge clk);
        wait_lo = !wait_n;
        repeat (4) @(negedge clk);
        data = d_out; ddir_on = ddir; inpack_lo = !inpack;
        iord = 1'b1;
        repeat (4) @(negedge clk);
        ce1 = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_edges(input int target, input string tag);
        int n = 0;
        while (sclk_edges < target && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(sclk_edges >= target), 32'd1);
    endtask

    initial begin
        logic [7:0] rd, exp_b;
        logic wl, dd, ip;
        int base, bad0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss", ss, 2'b11);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_ddir", ddir, 1'b0);
        chk("rst_inpack", inpack, 1'b1);
        chk("rst_wait", wait_n, 1'b1);
        chk("rst_dout", d_out, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        io_read(3'd1, rd, wl, dd, ip);
        chk("status_reset", rd, 8'h06);
        chk("rd_ddir", dd, 1'b1);
        chk("rd_inpack", ip, 1'b1);
        chk("rd_wait_low", wl, 1'b1);
        io_read(3'd0, rd, wl, dd, ip);
        chk("data_rx_empty", rd, 8'h00);
        io_write(3'd6, 8'hFF);
        io_read(3'd6, rd, wl, dd, ip);
        chk("reg6_zero", rd, 8'h00);

        // Mode 0 loopback, DIV=1
        loop_en = 1'b1;
        io_write(3'd2, 8'h01);
        io_write(3'd3, 8'h01);
        io_write(3'd5, 8'hFD);
        chk("ss_sel", ss, 2'b10);
        io_read(3'd5, rd, wl, dd, ip);
        chk("ssr_rd", rd, 8'h01);
        io_read(3'd3, rd, wl, dd, ip);
        chk("div_rd", rd, 8'h01);
        io_read(3'd4, rd, wl, dd, ip);
        chk("divhi_rd", rd, 8'h00);
        base = sclk_edges;
        io_write(3'd0, 8'hA5);
        sb_q.push_back(8'hA5);
        wait_edges(base + 16, "m0_edges");
        repeat (10) @(negedge clk);
        chk("m0_mosi", mosi_log, 8'hA5);
        chk("m0_half", edge_cyc[(base + 2) % 1024] - edge_cyc[(base + 1) % 1024], 2);
        chk("m0_period", edge_cyc[(base + 3) % 1024] - edge_cyc[(base + 1) % 1024], 4);
        chk("m0_latency", 32'(edge_cyc[(base + 1) % 1024] - raise_cyc <= 8), 32'd1);
        chk("m0_sclk_idle", sclk, 1'b0);
        io_read(3'd0, rd, wl, dd, ip);
        exp_b = sb_q.pop_front();
        chk("m0_rx", rd, exp_b);
        io_read(3'd1, rd, wl, dd, ip);
        chk("m0_rx_empty", rd[2], 1'b1);

        // Mode 3 loopback; irq_en bit reads 0 in the default build
        io_write(3'd2, 8'h0F);
        io_read(3'd2, rd, wl, dd, ip);
        chk("ctrl_rd", rd, 8'h07);
        chk("m3_sclk_idle", sclk, 1'b1);
        mon_cpol = 1'b1;
        mon_cpha = 1'b1;
        base = sclk_edges;
        bad0 = mosi_bad;
        io_write(3'd0, 8'h3C);
        sb_q.push_back(8'h3C);
        wait_edges(base + 16, "m3_edges");
        repeat (10) @(negedge clk);
        chk("m3_mosi", mosi_log, 8'h3C);
        chk("m3_mosi_on_fall", mosi_bad - bad0, 0);
        chk("m3_sclk_end", sclk, 1'b1);
        io_read(3'd0, rd, wl, dd, ip);
        exp_b = sb_q.pop_front();
        chk("m3_rx", rd, exp_b);

        // TX overflow with enable cleared
        io_write(3'd2, 8'h00);
        mon_cpol = 1'b0;
        mon_cpha = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            io_write(3'd0, 8'(8'h10 + i));
            if (i < DEPTH) sb_q.push_back(8'(8'h10 + i));
        end
        io_read(3'd1, rd, wl, dd, ip);
        chk("tx_ovf_status", rd, 8'h45);
        io_write(3'd1, 8'h40);
        io_read(3'd1, rd, wl, dd, ip);
        chk("tx_ovf_clear", rd, 8'h05);

        // Drain into RX until full, then one more transfer overflows RX
        io_write(3'd2, 8'h01);
        repeat (300) @(negedge clk);
        io_read(3'd1, rd, wl, dd, ip);
        chk("rx_full_status", rd, 8'h0A);
        io_write(3'd0, 8'hEE);
        repeat (100) @(negedge clk);
        io_read(3'd1, rd, wl, dd, ip);
        chk("rx_ovf_status", rd, 8'h2A);
        for (int i = 0; i < DEPTH; i++) begin
            io_read(3'd0, rd, wl, dd, ip);
            exp_b = sb_q.pop_front();
            chk($sformatf("rx_byte%0d", i), rd, exp_b);
        end
        io_read(3'd1, rd, wl, dd, ip);
        chk("rx_drained", rd, 8'h26);
        io_write(3'd1, 8'h20);
        io_read(3'd1, rd, wl, dd, ip);
        chk("rx_ovf_clear", rd, 8'h06);

        // Async reset in the middle of a byte
        io_write(3'd2, 8'h00);
        io_write(3'd3, 8'h03);
        io_write(3'd0, 8'h5A);
        io_write(3'd0, 8'h77);
        base = sclk_edges;
        io_write(3'd2, 8'h01);
        wait_edges(base + 5, "mid_edges");
        chk("mid_sclk_pre", sclk, 1'b1);
        chk("mid_ss_pre", ss, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ss", ss, 2'b11);
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_mosi", mosi, 1'b0);
        chk("mid_rst_dout", d_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        io_read(3'd1, rd, wl, dd, ip);
        chk("mid_rst_status", rd, 8'h06);
        io_read(3'd2, rd, wl, dd, ip);
        chk("mid_rst_ctrl", rd, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cf_io_spi_bridge.md
Name: cf_io_spi_bridge

Overview:
PC Card / CompactFlash I/O-mode slave that decodes host IORD/IOWR cycles into a small register file and drives a buffered SPI master.
- Successor to the fixed single-SS bus-to-SPI path, with parametrised chip-select count, FIFO depth, clock divider width, and configurable SPI mode.
- Sits between the card-edge top level (which owns the D tri-state and the PLL) and the SPI peripheral.
- Runs entirely in the PLL clock domain; host strobes are synchronised internally.

Parameters:
NUM_SS, 1, number of active-low SPI chip selects (1..8)
FIFO_DEPTH, 16, entries in each of the TX and RX byte FIFOs (power of two, 2..256)
DIV_W, 8, width of SCLK divider register (SCLK half-period = DIV+1 CLK cycles)

Ports:
CLK  in  1  PLL system clock
RESET  in  1  asynchronous active-low reset
D_in  in  8  host data bus, input side
D_out  out  8  host data bus, output side
DDIR  out  1  1 = drive D_out onto host bus
A  in  3  register address (host A[2:0])
CE1  in  1  card enable, active low
IORD  in  1  I/O read strobe, active low
IOWR  in  1  I/O write strobe, active low
WAIT  out  1  host wait, active low
INPACK  out  1  input acknowledge, active low
SS  out  NUM_SS  SPI chip selects, active low
SCLK  out  1  SPI clock
MOSI  out  1  SPI data out
MISO  in  1  SPI data in

Behaviour:
- Reset (RESET=0, async): D_out=0, DDIR=0, WAIT=1, INPACK=1, SS=all 1, SCLK=0, MOSI=0, FIFOs empty, CTRL=0, DIV=0, sticky flags clear.
- Reset mid-transfer aborts the SPI byte immediately and deasserts SS in the same instant.
- Host strobe handling:
  - CE1, IORD, IOWR and A pass through 2-FF synchronisers.
  - Cycle start = synced strobe falling edge with synced CE1=0.
  - WAIT = 0 while a raw strobe is low and the cycle is not yet acked. Ack is set on the cycle-start cycle and cleared on the synced strobe rising edge.
- Write cycle: D_in and A are sampled every CLK while synced IOWR=0. The register write commits on the synced IOWR rising edge using the last sample.
- Read cycle: on cycle start, the addressed register is latched into D_out; DDIR=1 and INPACK=0 until the synced IORD rising edge. A DATA read pops the RX FIFO on that rising edge.
- Register map:
  - 0 DATA: W pushes TX FIFO; R returns RX head. Read with RX empty returns 0x00 and does not pop.
  - 1 STATUS (R): [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] busy, [5] rx_ovf, [6] tx_ovf, [7] irq_pend. Writing 1 to [5] or [6] clears that flag.
  - 2 CTRL: [0] enable, [1] CPOL, [2] CPHA, [3] irq_en, others read 0.
  - 3 DIV: low byte of divider. 4 DIV_HI: upper DIV_W-8 bits (reads 0 if DIV_W=8).
  - 5 SSR: bit i=1 drives SS[i]=0; bits at or above NUM_SS are ignored.
  - 6, 7: read 0, writes ignored.
- Write to DATA with TX full: byte dropped, tx_ovf set.
- SPI FSM (IDLE, LOAD, SHIFT, DONE):
  - IDLE: SCLK=CPOL. Go to LOAD when enable=1 and TX not empty.
  - LOAD: pop TX into shift register (1 cycle); busy=1.
  - SHIFT: 8 bits, MSB first; 16 edges spaced DIV+1 CLKs.
    - CPHA=0: MOSI is set up before the first edge; MISO is sampled on odd edges.
    - CPHA=1: MOSI shifts on odd edges; MISO is sampled on even edges.
  - DONE: push received byte to RX. If RX full, byte dropped and rx_ovf set.
    - Next state: LOAD if TX non-empty and enable=1, else IDLE (SCLK returns to CPOL).
  - Clearing enable mid-byte completes the current byte, then goes to IDLE.
- Simultaneous host pop and SPI push on RX, or host push and SPI pop on TX: both take effect; count unchanged.
- Byte latency: TX write commit to first SCLK edge is at most 3+(DIV+1) CLKs.

Optional Feature:
CF_SPI_IREQ_EN:
- Defined: adds port IREQ out 1 (active low). IREQ=0 when irq_en=1 and (RX not empty, or TX empty with busy=0, or rx_ovf). irq_pend mirrors the asserted condition.
- Undefined: no IREQ port; CTRL[3] and STATUS[7] read 0.

Test Plan:
- Reset then STATUS read -> D_out=0x06, DDIR=1 and INPACK=0 during IORD, SS=all 1, SCLK=0.
- CTRL=0x01, DIV=1, SSR=0x01, write DATA=0xA5 with MISO looped to MOSI -> MOSI pattern 10100101, SCLK period 4 CLKs, DATA read returns 0xA5, STATUS[2]=1 after the read.
- CPOL=1, CPHA=1, DATA=0x3C -> SCLK idles 1; MOSI changes on falling edges; RX=0x3C via loopback.
- enable=0, write FIFO_DEPTH+1 bytes -> STATUS[0]=1, STATUS[6]=1; write 0x40 to STATUS -> STATUS[6]=0.
- RX full (FIFO_DEPTH bytes received, none read) plus one more transfer -> STATUS[5]=1; first FIFO_DEPTH bytes read back intact.
- Assert RESET mid-SHIFT -> SS=all 1, SCLK=CPOL reset value 0, FIFOs empty immediately, without waiting for a CLK edge.
